// File: rtl/uart_tx_fifo_send.sv
// rtl/uart_tx_fifo_send.sv - FIFO-buffered 8N1 UART transmitter; `define UART_TX_PARITY_EN adds an even-parity bit
module uart_tx_fifo_send #(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 115200,
    parameter int FIFO_AW  = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [7:0]         wr_data,
    output logic               fifo_full,
    output logic               fifo_empty,
    output logic [FIFO_AW:0]   fifo_level,
    output logic               overflow,
    output logic               tx,
    output logic               tx_busy,
    output logic               tx_done
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CW           = $clog2(CLKS_PER_BIT);
    localparam int DEPTH        = 2 ** FIFO_AW;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    logic [7:0]       mem [DEPTH];
    logic [FIFO_AW:0] wr_ptr;
    logic [FIFO_AW:0] rd_ptr;
    logic [7:0]       head;
    logic             push;
    logic             pop;
    logic             baud_tick;

    state_t           state;
    logic [CW-1:0]    baud_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift;
`ifdef UART_TX_PARITY_EN
    logic             parity_bit;
`endif

    // Flags derive only from the registered pointers, so a same-cycle pop never frees a slot early.
    assign fifo_level = wr_ptr - rd_ptr;
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                        (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
    assign head       = mem[rd_ptr[FIFO_AW-1:0]];
    assign push       = wr_en && !fifo_full;
    assign pop        = (state == IDLE) && !fifo_empty;
    assign baud_tick  = (baud_cnt == CW'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[FIFO_AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= wr_en && fifo_full;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            tx       <= 1'b1;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            tx_done  <= 1'b0;
            baud_cnt <= baud_tick ? '0 : baud_cnt + 1'b1;
            case (state)
                IDLE: begin
                    tx       <= 1'b1;
                    baud_cnt <= '0;
                    if (pop) begin
                        shift   <= head;
`ifdef UART_TX_PARITY_EN
                        parity_bit <= ^head;
`endif
                        state   <= START;
                        tx      <= 1'b0;
                        tx_busy <= 1'b1;
                    end
                end
                START: begin
                    if (baud_tick) begin
                        state   <= DATA;
                        bit_cnt <= '0;
                        tx      <= shift[0];
                    end
                end
                DATA: begin
                    if (baud_tick) begin
                        shift <= shift >> 1;
                        if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state <= PARITY;
                            tx    <= parity_bit;
`else
                            state <= STOP;
                            tx    <= 1'b1;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            tx      <= shift[1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (baud_tick) begin
                        state <= STOP;
                        tx    <= 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (baud_tick) begin
                        state   <= IDLE;
                        tx_busy <= 1'b0;
                        tx_done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
